fetch_unit: RTL

//  IF stage of the 5-stage RV32I pipeline. It is the consumer of the hazard unit's stall/flush outputs.
//  - Owns the PC and issues instruction-memory requests over a valid/ready request channel.
//  - Accepts variable-latency responses and drives the IF/ID pipeline register.
//  - Honours stall_PC, stall_ID and flush_IF_ID, and redirects on a taken branch/jump from EX (PCSel_EX).

---
 rtl/pipeline_pkg.sv | 23 ++
 rtl/if_id_reg.sv | 24 ++
 rtl/fetch_unit.sv | 103 ++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the RV32I pipeline stages.
// The IF/ID payload is a packed struct so stage registers stay generic.
package pipeline_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{valid: 1'b0, pc: '0, instr: NOP_INSTR};

endpackage

// File: rtl/if_id_reg.sv
// Generic stage register: flush beats stall, stall holds, otherwise
// load the offered word or fall back to a bubble.
module if_id_reg
    import pipeline_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   stall,
    input  logic   flush,
    input  logic   load,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= IF_ID_BUBBLE;
        else if (flush)
            q <= IF_ID_BUBBLE;
        else if (!stall)
            q <= load ? d : IF_ID_BUBBLE;
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues one imem request at a time over valid/ready,
// absorbs variable-latency responses and feeds the IF/ID register.
module fetch_unit
    import pipeline_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_PC,
    input  logic            stall_ID,
    input  logic            flush_IF_ID,
    input  logic            PCSel_EX,
    input  logic [XLEN-1:0] alu_target,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr
);

    fetch_state_t    state, state_n;
    logic [XLEN-1:0] pc, pc_n, req_addr_q, rsp_pc;
    logic            req_hold, discard, discard_n;
    if_id_t          buf_q, rsp_word, stage_d, stage_q;
    logic            kill, rsp_take, rsp_keep, to_buf, slot_free, start, accept;

    always_comb begin
        kill      = flush_IF_ID | PCSel_EX;
        rsp_take  = (state == WAIT) && imem_rsp_valid;
        rsp_keep  = rsp_take && !discard && !kill;
        to_buf    = rsp_keep && stall_ID;
        // A response leaving this cycle (not into the buffer) frees the slot,
        // which is what sustains one instruction per cycle on 1-cycle memory.
        slot_free = (state == FETCH) || (rsp_take && !to_buf);
        start     = rst_n && !req_hold && !stall_PC && !PCSel_EX && !discard && slot_free;

        imem_req_valid = req_hold || start;
        imem_req_addr  = req_hold ? req_addr_q : pc;
        accept         = imem_req_valid && imem_req_ready;

        state_n = state;
        case (state)
            FETCH:   if (accept) state_n = WAIT;
            WAIT:    if (rsp_take) state_n = to_buf ? HOLD : (accept ? WAIT : FETCH);
            HOLD:    if (PCSel_EX || (!stall_ID && !flush_IF_ID)) state_n = FETCH;
            default: state_n = FETCH;
        endcase

        // Only the request already in flight can be stale; a response landing
        // in the redirect cycle is dropped directly and needs no marker.
        discard_n = discard;
        if (PCSel_EX)
            discard_n = req_hold || ((state == WAIT) && !imem_rsp_valid);
        else if (rsp_take)
            discard_n = 1'b0;

        pc_n = pc;
        if (PCSel_EX)
            pc_n = alu_target & ~XLEN'(3);
        else if (accept && !discard)
            pc_n = pc + XLEN'(4);

        rsp_word = '{valid: 1'b1, pc: rsp_pc, instr: imem_rsp_data};
        stage_d  = (state == HOLD) ? buf_q : rsp_word;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            req_addr_q <= RESET_PC;
            rsp_pc     <= '0;
            req_hold   <= 1'b0;
            discard    <= 1'b0;
            buf_q      <= IF_ID_BUBBLE;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            discard  <= discard_n;
            req_hold <= imem_req_valid && !imem_req_ready;
            if (start)  req_addr_q <= pc;
            if (accept) rsp_pc     <= imem_req_addr;
            if (to_buf) buf_q      <= rsp_word;
        end
    end

    if_id_reg u_if_id (
        .clk   (clk),
        .rst_n (rst_n),
        .stall (stall_ID),
        .flush (kill),
        .load  ((state == HOLD) || rsp_keep),
        .d     (stage_d),
        .q     (stage_q)
    );

    assign if_id_valid = stage_q.valid;
    assign if_id_pc    = stage_q.pc;
    assign if_id_instr = stage_q.instr;

endmodule
